// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone classic slave backed by a word-addressed memory.
// Supports programmable wait states, error termination for out-of-range
// word indices, bus aborts during the wait phase and a backdoor load port.
module wb_slave_mem #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic [31:0]              wbs_dat_o,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  output logic                     wbs_ack_o,
  output logic                     wbs_err_o,
  input  logic                     ld_en_i,
  input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
  input  logic [31:0]              ld_data_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [29:0]   adr_q;
  logic [31:0]   dat_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   mem [DEPTH];

  logic          req;
  logic [29:0]   cur_word;
  logic [31:0]   cur_dat;
  logic          cur_we;
  logic [3:0]    cur_sel;
  logic [AW-1:0] cur_idx;
  logic          in_range;
  logic          go_resp;
  logic          unused_adr_bits;

  assign unused_adr_bits = ^wbs_adr_i[1:0];

  // The edge that enters RESP is also the sampling edge when there are no wait
  // states, so the live bus fields are used in IDLE and the latched ones after.
  always_comb begin
    req      = wbs_cyc_i && wbs_stb_i;
    cur_word = (state == IDLE) ? wbs_adr_i[31:2] : adr_q;
    cur_dat  = (state == IDLE) ? wbs_dat_i : dat_q;
    cur_we   = (state == IDLE) ? wbs_we_i : we_q;
    cur_sel  = (state == IDLE) ? wbs_sel_i : sel_q;
    cur_idx  = cur_word[AW-1:0];
    in_range = (cur_word[29:AW] == '0);
    go_resp  = wb_rst_ni && req &&
               (((state == IDLE) && (WAIT_STATES == 0)) ||
                ((state == WAIT) && (cnt == 4'd1)));
  end

  // Memory array: backdoor load first, bus byte lanes later so they win on a shared word.
  always_ff @(posedge wb_clk_i) begin
    if (ld_en_i && wb_rst_ni) mem[ld_addr_i] <= ld_data_i;
    if (go_resp && cur_we && in_range) begin
      if (cur_sel[0]) mem[cur_idx][7:0]   <= cur_dat[7:0];
      if (cur_sel[1]) mem[cur_idx][15:8]  <= cur_dat[15:8];
      if (cur_sel[2]) mem[cur_idx][23:16] <= cur_dat[23:16];
      if (cur_sel[3]) mem[cur_idx][31:24] <= cur_dat[31:24];
    end
  end

  // Transaction FSM with registered ack/err pulses and read data.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            adr_q <= wbs_adr_i[31:2];
            dat_q <= wbs_dat_i;
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WS;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        wbs_ack_o <= in_range;
        wbs_err_o <= !in_range;
        if (!cur_we) wbs_dat_o <= in_range ? mem[cur_idx] : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_mem.sv
// tb_wb_slave_mem: directed self-checking bench for wb_slave_mem.
// Three instances (0, 3 and 5 wait states) share the data path and backdoor
// port; each has its own cyc/stb so only one is addressed at a time.
module tb_wb_slave_mem;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cyc;
  logic [2:0]  stb;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [31:0] rdat [3];
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  int checks = 0;
  int errors = 0;

  wb_slave_mem #(.DEPTH(1024), .WAIT_STATES(0)) u0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_dat_o(rdat[0]), .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb[0]),
    .wbs_cyc_i(cyc[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  wb_slave_mem #(.DEPTH(1024), .WAIT_STATES(3)) u1 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_dat_o(rdat[1]), .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb[1]),
    .wbs_cyc_i(cyc[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  wb_slave_mem #(.DEPTH(1024), .WAIT_STATES(5)) u2 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_dat_o(rdat[2]), .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb[2]),
    .wbs_cyc_i(cyc[2]), .wbs_ack_o(ack[2]), .wbs_err_o(err[2]),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case a step waits forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one observed value against its expectation and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected transaction status word: latency, ack, err, and quiet-after-pulse flag.
  function automatic logic [31:0] stat(input int lat, input logic a, input logic e);
    return {21'h0, 8'(lat), a, e, 1'b1};
  endfunction

  // One bus transaction on instance d, started at a falling edge. Any backdoor
  // strobe set by the caller lasts only for the sampling edge.
  task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                               input logic [31:0] dt, input logic [3:0] s,
                               output logic [31:0] st);
    int   lat;
    logic a_seen;
    logic e_seen;
    logic quiet;
    adr = a; wdat = dt; we = w; sel = s;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    lat = 0; a_seen = 1'b0; e_seen = 1'b0;
    while (lat < 40 && !a_seen && !e_seen) begin
      @(negedge clk);
      lat++;
      ld_en = 1'b0;
      a_seen = ack[d];
      e_seen = err[d];
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(negedge clk);
    quiet = !(ack[d] || err[d]);
    st = {21'h0, 8'(lat), a_seen, e_seen, quiet};
  endtask

  // Single-cycle backdoor write, aligned to falling edges.
  task automatic backdoor(input logic [9:0] a, input logic [31:0] v);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    logic [31:0] st;
    logic [31:0] v;
    logic [3:0]  pat;
    logic        seen;
    clk = 1'b0; rst_n = 1'b0;
    adr = '0; wdat = '0; we = 1'b0; sel = '0; cyc = '0; stb = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);

    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset_dat_%0d", d), rdat[d], 32'h0);
      checkOutput($sformatf("reset_ackerr_%0d", d), {30'h0, ack[d], err[d]}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    backdoor(10'd0, 32'h3fc00093);
    backdoor(10'd255, 32'hAABBCCDD);
    backdoor(10'd4, 32'h12345678);

    // Zero wait states: read of a preloaded word.
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'hF, st);
    checkOutput("ws0_read_stat", st, stat(1, 1'b1, 1'b0));
    checkOutput("ws0_read_dat", rdat[0], 32'h3fc00093);

    // Three wait states: partial byte-lane write, then read back.
    applyStimulus(1, 1'b1, 32'h3fc, 32'h11223344, 4'b0101, st);
    checkOutput("ws3_write_stat", st, stat(4, 1'b1, 1'b0));
    applyStimulus(1, 1'b0, 32'h3fc, 32'h0, 4'hF, st);
    checkOutput("ws3_read_stat", st, stat(4, 1'b1, 1'b0));
    checkOutput("ws3_read_dat", rdat[1], 32'hAA22CC44);

    // Out-of-range read and write terminate with err; word 0 must not alias.
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'hF, st);
    checkOutput("oob_read_stat", st, stat(1, 1'b0, 1'b1));
    checkOutput("oob_read_dat", rdat[0], 32'h0);
    applyStimulus(0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, st);
    checkOutput("oob_write_stat", st, stat(1, 1'b0, 1'b1));
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'hF, st);
    checkOutput("oob_alias_dat", rdat[0], 32'h3fc00093);

    // Five wait states: abort mid-wait, then a normal read.
    adr = 32'h10; wdat = 32'hFFFFFFFF; we = 1'b1; sel = 4'hF;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | ack[2] | err[2];
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | ack[2] | err[2];
    end
    checkOutput("abort_no_resp", {31'h0, seen}, 32'h0);
    applyStimulus(2, 1'b0, 32'h10, 32'h0, 4'hF, st);
    checkOutput("abort_next_stat", st, stat(6, 1'b1, 1'b0));
    checkOutput("abort_word_kept", rdat[2], 32'h12345678);

    // Back-to-back reads with strobe held: ack every other cycle.
    adr = 32'h0; we = 1'b0; sel = 4'hF;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    pat = '0;
    repeat (4) begin
      @(negedge clk);
      pat = {pat[2:0], ack[0]};
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    checkOutput("b2b_ack_pattern", {28'h0, pat}, 32'h0000000A);

    // Read-increment-write loop on one word.
    backdoor(10'd255, 32'h0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1'b0, 32'h3fc, 32'h0, 4'hF, st);
      checkOutput($sformatf("loop_rd_stat_%0d", i), st, stat(1, 1'b1, 1'b0));
      checkOutput($sformatf("loop_rd_dat_%0d", i), rdat[0], 32'(i));
      v = rdat[0] + 32'd1;
      applyStimulus(0, 1'b1, 32'h3fc, v, 4'hF, st);
      checkOutput($sformatf("loop_wr_stat_%0d", i), st, stat(1, 1'b1, 1'b0));
    end
    applyStimulus(0, 1'b0, 32'h3fc, 32'h0, 4'hF, st);
    checkOutput("loop_final", rdat[0], 32'h0000000A);

    // Backdoor and bus write to the same word on the same edge merge by lane.
    ld_en = 1'b1; ld_addr = 10'd255; ld_data = 32'h55667788;
    applyStimulus(0, 1'b1, 32'h3fc, 32'h11223344, 4'b0011, st);
    checkOutput("merge_stat", st, stat(1, 1'b1, 1'b0));
    applyStimulus(0, 1'b0, 32'h3fc, 32'h0, 4'hF, st);
    checkOutput("merge_dat", rdat[0], 32'h55663344);

    // Backdoor write racing a bus read returns the old word.
    ld_en = 1'b1; ld_addr = 10'd255; ld_data = 32'h99999999;
    applyStimulus(0, 1'b0, 32'h3fc, 32'h0, 4'hF, st);
    checkOutput("race_old_dat", rdat[0], 32'h55663344);
    applyStimulus(0, 1'b0, 32'h3fc, 32'h0, 4'hF, st);
    checkOutput("race_new_dat", rdat[0], 32'h99999999);

    // Write with no lanes enabled still acks and leaves memory alone.
    applyStimulus(0, 1'b1, 32'h3fc, 32'h0, 4'h0, st);
    checkOutput("sel0_stat", st, stat(1, 1'b1, 1'b0));
    applyStimulus(0, 1'b0, 32'h3fc, 32'h0, 4'hF, st);
    checkOutput("sel0_dat", rdat[0], 32'h99999999);

    // Asynchronous reset in the middle of a wait phase.
    checkOutput("pre_rst_dat", rdat[1], 32'hAA22CC44);
    adr = 32'h3fc; wdat = 32'h0; we = 1'b1; sel = 4'hF;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_dat", rdat[1], 32'h0);
    checkOutput("async_rst_ackerr", {30'h0, ack[1], err[1]}, 32'h0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    backdoor(10'd0, 32'hBAD0BAD0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'hF, st);
    checkOutput("post_rst_first_stat", st, stat(1, 1'b1, 1'b0));
    checkOutput("post_rst_mem_kept", rdat[0], 32'h3fc00093);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | ack[1] | err[1];
    end
    checkOutput("post_rst_no_ack", {31'h0, seen}, 32'h0);
    applyStimulus(1, 1'b0, 32'h3fc, 32'h0, 4'hF, st);
    checkOutput("post_rst_ws3_stat", st, stat(4, 1'b1, 1'b0));
    checkOutput("post_rst_ws3_dat", rdat[1], 32'h99999999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 Parameter DEPTH, default 1024, memory size in 32-bit words (power of two, 2..65536).
REQ-002 Parameter WAIT_STATES, default 0, extra cycles inserted before each ack/err (0..15).
REQ-003 wb_clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 wbs_adr_i  in  32  byte address; word index = wbs_adr_i[31:2]; bits [1:0] ignored.
REQ-006 wbs_dat_i  in  32  write data.
REQ-007 wbs_dat_o  out  32  read data.
REQ-008 wbs_we_i  in  1  1 = write, 0 = read.
REQ-009 wbs_sel_i  in  4  byte-lane enables; bit n covers data bits [8n+7:8n].
REQ-010 wbs_stb_i  in  1  strobe.
REQ-011 wbs_cyc_i  in  1  bus cycle valid.
REQ-012 wbs_ack_o  out  1  normal termination, one-cycle pulse.
REQ-013 wbs_err_o  out  1  error termination, one-cycle pulse.
REQ-014 ld_en_i  in  1  backdoor load strobe, used for program preload.
REQ-015 ld_addr_i  in  $clog2(DEPTH)  backdoor word index.
REQ-016 ld_data_i  in  32  backdoor word data.

Function
REQ-017 FSM states IDLE, WAIT, RESP; WAIT counter is $clog2(16) bits.
REQ-018 IDLE: wbs_cyc_i && wbs_stb_i sampled high -> latch adr/we/sel/dat; go WAIT with counter = WAIT_STATES when WAIT_STATES > 0, otherwise go RESP directly.
REQ-019 WAIT: counter decrements each edge; at counter == 1 (or on entry for WAIT_STATES = 1) next state RESP; request sampled at edge k yields ack/err high in the cycle following edge k+WAIT_STATES.
REQ-020 RESP: exactly one of wbs_ack_o/wbs_err_o high for exactly one cycle; next edge -> IDLE unconditionally; no request accepted on the RESP->IDLE edge.
REQ-021 Back-to-back: with stb held high, second request is sampled in IDLE one cycle after RESP (minimum 2-cycle spacing at WAIT_STATES = 0).
REQ-022 Write: bytes with sel bit set updated on the edge that enters RESP; sel = 4'b0000 still acks, memory unchanged.
REQ-023 Read: wbs_dat_o loaded with full word (sel ignored) on the edge entering RESP; holds value until next read response.
REQ-024 Word index >= DEPTH: wbs_err_o instead of ack, same latency, no memory write, wbs_dat_o loaded with 32'h0 for reads.
REQ-025 Abort: wbs_cyc_i or wbs_stb_i low on any edge while in WAIT -> IDLE, no write, no ack/err.
REQ-026 Latched request fields used for the whole transaction; input changes during WAIT ignored (except abort per REQ-025).
REQ-027 Backdoor: ld_en_i high writes ld_data_i to ld_addr_i on that edge in any state.
REQ-028 Simultaneous backdoor and bus write to same word: bus-enabled bytes take bus data, remaining bytes take ld_data_i.
REQ-029 Backdoor write and bus read of same word on same edge: read returns the pre-edge (old) word.
REQ-030 ack and err never high together; neither is asserted without a preceding accepted request.

Reset
REQ-031 wb_rst_ni low asynchronously forces state IDLE, counter 0, wbs_ack_o 0, wbs_err_o 0, wbs_dat_o 32'h0.
REQ-032 Memory contents are not cleared by reset; backdoor writes are ignored while wb_rst_ni low.
REQ-033 Reset asserted mid-transaction: transaction dropped, no write, no ack after release; first request accepted on first edge after release.

Verification
REQ-034 WS=0: backdoor word 0 = 32'h3fc00093; read adr 0 -> ack one cycle after sampling edge, wbs_dat_o = 32'h3fc00093.
REQ-035 WS=3: write adr 32'h3fc, dat 32'h11223344, sel 4'b0101 over old 32'hAABBCCDD -> ack at 4th edge after sample; read back 32'hAA22CC44.
REQ-036 DEPTH=1024: read adr 32'h1000 -> wbs_err_o one pulse, wbs_ack_o 0, wbs_dat_o 32'h0; memory unchanged.
REQ-037 WS=5: write request, drop stb after 2 cycles -> no ack/err, target word unchanged; next request completes normally.
REQ-038 Loop of read, write of read+1 to adr 32'h3fc starting at 0, 10 iterations -> final word 32'h0000000A, each ack exactly one cycle.
REQ-039 Assert wb_rst_ni low between clock edges during WAIT -> ack/err/dat_o immediately 0; after release no ack; memory preserved.
